// File: rtl/iter_shift_ctrl.sv
// Iterative SLL/SRL/SRA sequencer: one single-bit shift per cycle, done pulses shamt+1 cycles after accept.
// ready is high in IDLE/DONE; a start seen while busy is dropped, not queued.
module iter_shift_ctrl #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             ready,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_result;
  logic [SHW-1:0]   r_count;
  logic [1:0]       r_op;

  logic             w_ready;
  logic             w_accept;
  logic             w_pass;
  logic             w_last;
  logic [WIDTH-1:0] w_step;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_result_nxt;
  logic [SHW-1:0]   w_count_nxt;
  logic [1:0]       w_op_nxt;

  assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept = w_ready && start;
  // Zero shift and the reserved op bypass SHIFT and finish the next cycle.
  assign w_pass   = (shamt == '0) || (op == OP_RSV);
  assign w_last   = (r_count == SHW'(1));

  always_comb begin
    w_step = r_result;
    case (r_op)
      OP_SLL:  w_step = {r_result[WIDTH-2:0], 1'b0};
      OP_SRL:  w_step = {1'b0, r_result[WIDTH-1:1]};
      OP_SRA:  w_step = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
      default: w_step = r_result;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_count_nxt  = r_count;
    w_op_nxt     = r_op;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_result_nxt = data_in;
          w_op_nxt     = op;
          w_count_nxt  = shamt;
          w_state_nxt  = w_pass ? ST_DONE : ST_SHIFT;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        w_result_nxt = w_step;
        w_count_nxt  = r_count - SHW'(1);
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_count  <= '0;
      r_op     <= OP_SLL;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_count  <= w_count_nxt;
      r_op     <= w_op_nxt;
    end
  end

  assign result = r_result;
  assign busy   = (r_state == ST_SHIFT);
  assign done   = (r_state == ST_DONE);
  assign ready  = w_ready;

endmodule
